// File: rtl/breakout_ball_ctrl.sv
// Ball owner for the breakout playfield: collects column bounce requests, steps the ball,
// and handles walls, paddle bounce, launch, miss and lives.
module breakout_ball_ctrl #(
  parameter int unsigned NCOL      = 7,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned SCREEN_W  = 800,
  parameter int unsigned SCREEN_H  = 600,
  parameter int unsigned TICK_DIV  = 200000,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned MISS_HOLD = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCOL-1:0] move_u,
  input  logic [NCOL-1:0] move_d,
  input  logic [NCOL-1:0] move_l,
  input  logic [NCOL-1:0] move_r,
  input  logic [10:0]     paddle_x_l,
  input  logic [10:0]     paddle_x_r,
  input  logic [10:0]     paddle_y_t,
  input  logic            launch,
  input  logic [10:0]     pix_x,
  input  logic [10:0]     pix_y,
  output logic [10:0]     ball_x_l,
  output logic [10:0]     ball_x_r,
  output logic [10:0]     ball_y_t,
  output logic [10:0]     ball_y_b,
  output logic            ball_ON,
  output logic            miss,
  output logic [1:0]      lives,
  output logic            game_over
);

  localparam int unsigned CW = 11;
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

  localparam logic [CW-1:0] X_EDGE = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] Y_EDGE = CW'(SCREEN_H - 1);
  localparam logic [CW-1:0] X_MAX  = CW'(SCREEN_W - BALL_SIZE);
  localparam logic [CW-1:0] Y_MAX  = CW'(SCREEN_H - BALL_SIZE);
  localparam logic [CW-1:0] SZ     = CW'(BALL_SIZE);
  localparam logic [CW-1:0] SZM1   = CW'(BALL_SIZE - 1);
  localparam logic [CW-1:0] HALF   = CW'(BALL_SIZE / 2);

  typedef enum logic [1:0] {IDLE, RUN, MISS, GAME_OVER} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div;
  logic            step;
  logic            launch_q, launch_rise;
  logic            pend_u, pend_d, pend_l, pend_r;
  logic            hit_u, hit_d, hit_l, hit_r;
  logic            dir_x, dir_dn;
  logic            dx_n, dy_n;
  logic [MW-1:0]   miss_cnt;
  logic            at_bottom, hold_done;
  logic [CW:0]     mid_sum;
  logic [CW-1:0]   mid, idle_x_l, idle_y_t, pad_row;
  logic [CW-1:0]   nx_l, ny_t;

  assign step        = (div == DW'(TICK_DIV - 1));
  assign launch_rise = launch & ~launch_q;
  assign hit_u       = |move_u;
  assign hit_d       = |move_d;
  assign hit_l       = |move_l;
  assign hit_r       = |move_r;
  assign at_bottom   = (ball_y_b == Y_EDGE);
  assign hold_done   = (miss_cnt == MW'(MISS_HOLD - 1));
  assign pad_row     = paddle_y_t - CW'(1);

  // Free-running step divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (step) div <= '0;
    else           div <= div + DW'(1);
  end

  // Resting position centred on the paddle, clamped to the playfield
  always_comb begin
    mid_sum  = {1'b0, paddle_x_l} + {1'b0, paddle_x_r};
    mid      = mid_sum[CW:1];
    idle_x_l = (mid < HALF) ? '0 : mid - HALF;
    if (idle_x_l > X_MAX) idle_x_l = X_MAX;
    idle_y_t = (paddle_y_t < SZ) ? '0 : paddle_y_t - SZ;
    if (idle_y_t > Y_MAX) idle_y_t = Y_MAX;
  end

  // Step direction resolution: hits, then walls, then paddle; then a clamped 1 px move
  always_comb begin
    dx_n = dir_x;
    dy_n = dir_dn;
    if (pend_l && pend_r) dx_n = ~dir_x;
    else if (pend_r)      dx_n = 1'b1;
    else if (pend_l)      dx_n = 1'b0;
    if (pend_u && pend_d) dy_n = ~dir_dn;
    else if (pend_d)      dy_n = 1'b1;
    else if (pend_u)      dy_n = 1'b0;
    if (ball_x_l == '0)          dx_n = 1'b1;
    else if (ball_x_r == X_EDGE) dx_n = 1'b0;
    if (ball_y_t == '0)          dy_n = 1'b1;
    if (dy_n && (ball_y_b == pad_row) &&
        (ball_x_r >= paddle_x_l) && (ball_x_l <= paddle_x_r)) dy_n = 1'b0;
    nx_l = ball_x_l;
    ny_t = ball_y_t;
    if (dx_n && (ball_x_r != X_EDGE))  nx_l = ball_x_l + CW'(1);
    else if (!dx_n && (ball_x_l != '0)) nx_l = ball_x_l - CW'(1);
    if (dy_n && (ball_y_b != Y_EDGE))  ny_t = ball_y_t + CW'(1);
    else if (!dy_n && (ball_y_t != '0)) ny_t = ball_y_t - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (launch_rise) state_next = RUN;
      RUN:       if (step && at_bottom) state_next = MISS;
      MISS:      if (step && hold_done) state_next = (lives == 2'd0) ? GAME_OVER : IDLE;
      GAME_OVER: state_next = GAME_OVER;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ball_ON = 1'b0;
    if ((state != MISS) && (state != GAME_OVER) &&
        (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
        (pix_y >= ball_y_t) && (pix_y <= ball_y_b)) ball_ON = 1'b1;
  end

  // Ball box, direction, pending hits, lives and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launch_q  <= 1'b0;
      ball_x_l  <= '0;
      ball_x_r  <= SZM1;
      ball_y_t  <= '0;
      ball_y_b  <= SZM1;
      dir_x     <= 1'b1;
      dir_dn    <= 1'b0;
      pend_u    <= 1'b0;
      pend_d    <= 1'b0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      miss_cnt  <= '0;
      lives     <= 2'(LIVES);
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      launch_q  <= launch;
      miss      <= (state == RUN) && (state_next == MISS);
      game_over <= (state_next == GAME_OVER);
      case (state)
        IDLE: begin
          ball_x_l <= idle_x_l;
          ball_x_r <= idle_x_l + SZM1;
          ball_y_t <= idle_y_t;
          ball_y_b <= idle_y_t + SZM1;
          dir_x    <= 1'b1;
          dir_dn   <= 1'b0;
          pend_u   <= 1'b0;
          pend_d   <= 1'b0;
          pend_l   <= 1'b0;
          pend_r   <= 1'b0;
          miss_cnt <= '0;
        end
        RUN: begin
          if (step) begin
            // requests arriving on the step clock carry over to the next step
            pend_u <= hit_u;
            pend_d <= hit_d;
            pend_l <= hit_l;
            pend_r <= hit_r;
            if (at_bottom) begin
              miss_cnt <= '0;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end else begin
              dir_x    <= dx_n;
              dir_dn   <= dy_n;
              ball_x_l <= nx_l;
              ball_x_r <= nx_l + SZM1;
              ball_y_t <= ny_t;
              ball_y_b <= ny_t + SZM1;
            end
          end else begin
            pend_u <= pend_u | hit_u;
            pend_d <= pend_d | hit_d;
            pend_l <= pend_l | hit_l;
            pend_r <= pend_r | hit_r;
          end
        end
        MISS: begin
          if (step) miss_cnt <= miss_cnt + MW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
